// File: rtl/gerador_tom_pkg.sv
// Shared definitions for the note generator: note codes, pitch table, FSM states
// and the half-period helper evaluated at elaboration.
package gerador_tom_pkg;

  localparam logic [2:0] NOTA_SILENCIO = 3'd0;
  localparam logic [2:0] NOTA_DO       = 3'd1;
  localparam logic [2:0] NOTA_RE       = 3'd2;
  localparam logic [2:0] NOTA_MI       = 3'd3;
  localparam logic [2:0] NOTA_FA       = 3'd4;
  localparam logic [2:0] NOTA_SOL      = 3'd5;
  localparam logic [2:0] NOTA_LA       = 3'd6;
  localparam logic [2:0] NOTA_SI       = 3'd7;

  // Note frequencies in centi-Hz, C4 through B4.
  localparam int unsigned F_CENTI [7] = '{26163, 29366, 32963, 34923, 39200, 44000, 49388};

  typedef enum logic [1:0] {
    SILENCIO = 2'd0,
    TOCANDO  = 2'd1,
    ARTIC    = 2'd2
  } estado_t;

  // Half-period in clock cycles: floor(clk_hz * 50 / f_centi).
  function automatic int unsigned half_period(input longint unsigned clk_hz,
                                              input logic [2:0] code);
    longint unsigned f;
    longint unsigned q;
    if (code == NOTA_SILENCIO) begin
      return 0;
    end
    f = longint'(F_CENTI[int'(code) - 1]);
    q = (clk_hz * 64'd50) / f;
    return int'(q[31:0]);
  endfunction

endpackage

// File: rtl/gerador_tom_filtro.sv
// Glitch filter: registers the request, then accepts it only after it has been
// held unchanged for STABLE_CYCLES consecutive cycles.
module filtro_estavel
  #(
    parameter int unsigned N             = 3,
    parameter int unsigned STABLE_CYCLES = 4
  ) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] entrada,
    output logic [N-1:0] aceito
  );

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [N-1:0]  entrada_q;
  logic [N-1:0]  cand_q, cand_d;
  logic [N-1:0]  aceito_q, aceito_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    aceito_d = aceito_q;
    if (entrada_q != cand_q) begin
      cand_d = entrada_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Accept on the same edge the counter reaches its final value.
    if ((cnt_d == CNT_MAX) && (cand_d != aceito_q)) begin
      aceito_d = cand_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entrada_q <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      aceito_q  <= '0;
    end else begin
      entrada_q <= entrada;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      aceito_q  <= aceito_d;
    end
  end

  assign aceito = aceito_q;

endmodule

// File: rtl/gerador_tom.sv
// Buzzer tone generator: filters the note request, then plays a square wave with
// a silent articulation gap between consecutive distinct notes.
module gerador_tom
  import gerador_tom_pkg::*;
  #(
    parameter int unsigned CLK_HZ        = 50000000,
    parameter int unsigned DIV_W         = 17,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 1000
  ) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] nota,
    output logic       buzzer,
    output logic       tocando,
    output logic [2:0] nota_atual,
    output logic       troca
  );

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_M1 = GAP_W'(GAP_CYCLES - 1);

  localparam logic [DIV_W-1:0] HM1_DO  = DIV_W'(half_period(CLK_HZ, NOTA_DO) - 1);
  localparam logic [DIV_W-1:0] HM1_RE  = DIV_W'(half_period(CLK_HZ, NOTA_RE) - 1);
  localparam logic [DIV_W-1:0] HM1_MI  = DIV_W'(half_period(CLK_HZ, NOTA_MI) - 1);
  localparam logic [DIV_W-1:0] HM1_FA  = DIV_W'(half_period(CLK_HZ, NOTA_FA) - 1);
  localparam logic [DIV_W-1:0] HM1_SOL = DIV_W'(half_period(CLK_HZ, NOTA_SOL) - 1);
  localparam logic [DIV_W-1:0] HM1_LA  = DIV_W'(half_period(CLK_HZ, NOTA_LA) - 1);
  localparam logic [DIV_W-1:0] HM1_SI  = DIV_W'(half_period(CLK_HZ, NOTA_SI) - 1);

  function automatic logic [DIV_W-1:0] half_m1(input logic [2:0] code);
    case (code)
      NOTA_DO:  return HM1_DO;
      NOTA_RE:  return HM1_RE;
      NOTA_MI:  return HM1_MI;
      NOTA_FA:  return HM1_FA;
      NOTA_SOL: return HM1_SOL;
      NOTA_LA:  return HM1_LA;
      NOTA_SI:  return HM1_SI;
      default:  return '0;
    endcase
  endfunction

  logic [2:0]       req;
  logic [2:0]       a;
  estado_t          state_q, state_d;
  logic [2:0]       cur_q, cur_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             buzzer_q, buzzer_d;
  logic             troca_q, troca_d;

  assign req = enable ? nota : NOTA_SILENCIO;

  filtro_estavel #(
    .N             (3),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filtro (
    .clock   (clock),
    .reset   (reset),
    .entrada (req),
    .aceito  (a)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= SILENCIO;
      cur_q    <= NOTA_SILENCIO;
      div_q    <= '0;
      gap_q    <= '0;
      buzzer_q <= 1'b0;
      troca_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
      buzzer_q <= buzzer_d;
      troca_q  <= troca_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SILENCIO: begin
        if (a != NOTA_SILENCIO) state_d = TOCANDO;
      end
      TOCANDO: begin
        if (a == NOTA_SILENCIO) begin
          state_d = SILENCIO;
        end else if (a != cur_q) begin
          state_d = ARTIC;
        end
      end
      ARTIC: begin
        if (gap_q == '0) state_d = (a != NOTA_SILENCIO) ? TOCANDO : SILENCIO;
      end
      default: state_d = SILENCIO;
    endcase
  end

  always_comb begin
    cur_d    = cur_q;
    div_d    = div_q;
    gap_d    = gap_q;
    buzzer_d = buzzer_q;
    troca_d  = 1'b0;
    unique case (state_q)
      SILENCIO: begin
        buzzer_d = 1'b0;
        if (a != NOTA_SILENCIO) begin
          cur_d    = a;
          buzzer_d = 1'b1;
          div_d    = half_m1(a);
          troca_d  = 1'b1;
        end
      end
      TOCANDO: begin
        if (a == NOTA_SILENCIO) begin
          buzzer_d = 1'b0;
        end else if (a != cur_q) begin
          buzzer_d = 1'b0;
          gap_d    = GAP_M1;
        end else if (div_q == '0) begin
          buzzer_d = ~buzzer_q;
          div_d    = half_m1(cur_q);
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      ARTIC: begin
        buzzer_d = 1'b0;
        if (gap_q == '0) begin
          // Gap over: start whatever is requested now, not the note that caused the gap.
          if (a != NOTA_SILENCIO) begin
            cur_d    = a;
            buzzer_d = 1'b1;
            div_d    = half_m1(a);
            troca_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        buzzer_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    tocando    = (state_q == TOCANDO);
    buzzer     = buzzer_q;
    troca      = troca_q;
    nota_atual = a;
  end

endmodule

// File: tb/tb_gerador_tom.sv
// Self-checking bench for gerador_tom with a scaled-down clock so whole periods fit.
module tb_gerador_tom;

  localparam int unsigned TB_CLK_HZ = 100000;  // C4 half 191, A4 half 113, B4 half 101
  localparam int STABLE = 4;
  localparam int GAP    = 20;
  localparam int M_SIL  = 0;
  localparam int M_TOC  = 1;
  localparam int M_ART  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] nota = 3'd0;
  logic       buzzer, tocando, troca;
  logic [2:0] nota_atual;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_hist [STABLE];
  int m_acc = 0;
  int m_state = M_SIL;
  int m_cur = 0;
  int m_t = 0;
  int m_gap_n = 0;
  bit m_buz = 1'b0;
  bit m_troca = 1'b0;

  gerador_tom #(
    .CLK_HZ        (TB_CLK_HZ),
    .DIV_W         (17),
    .STABLE_CYCLES (STABLE),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .nota       (nota),
    .buzzer     (buzzer),
    .tocando    (tocando),
    .nota_atual (nota_atual),
    .troca      (troca)
  );

  always #5 clock = ~clock;

  function automatic int half_ref(input int k);
    int f;
    case (k)
      1: f = 26163;
      2: f = 29366;
      3: f = 32963;
      4: f = 34923;
      5: f = 39200;
      6: f = 44000;
      default: f = 49388;
    endcase
    return (TB_CLK_HZ * 50) / f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < STABLE; i++) m_hist[i] = 0;
    m_acc = 0; m_state = M_SIL; m_cur = 0; m_t = 0; m_gap_n = 0;
    m_buz = 1'b0; m_troca = 1'b0;
  endtask

  task automatic model_start(input int code);
    m_state = M_TOC; m_cur = code; m_t = 0; m_buz = 1'b1; m_troca = 1'b1;
  endtask

  // One clock edge: FSM reacts to the accepted code as it was before the edge.
  task automatic model_step();
    int a;
    int r;
    bit same;
    a = m_acc;
    r = enable ? int'(nota) : 0;
    m_troca = 1'b0;
    case (m_state)
      M_SIL: if (a != 0) model_start(a);
      M_TOC: begin
        if (a == 0) begin
          m_state = M_SIL; m_buz = 1'b0;
        end else if (a != m_cur) begin
          m_state = M_ART; m_gap_n = 0; m_buz = 1'b0;
        end else begin
          m_t++;
          m_buz = ((m_t / half_ref(m_cur)) % 2) == 0;
        end
      end
      default: begin
        if (m_gap_n == GAP - 1) begin
          if (a != 0) model_start(a);
          else m_state = M_SIL;
        end else begin
          m_gap_n++;
        end
      end
    endcase
    // Accepted code: the last STABLE sampled requests all agree.
    same = 1'b1;
    for (int i = 1; i < STABLE; i++) if (m_hist[i] != m_hist[0]) same = 1'b0;
    if (same) m_acc = m_hist[0];
    for (int i = 0; i < STABLE - 1; i++) m_hist[i] = m_hist[i+1];
    m_hist[STABLE-1] = r;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      if (reset) model_step();
      #1;
      n_cmp++;
      if (buzzer !== m_buz || tocando !== (m_state == M_TOC) ||
          nota_atual !== 3'(m_acc) || troca !== m_troca) begin
        n_fail++;
        $display("FAIL model t=%0t buzzer=%b/%b tocando=%b/%b nota_atual=%0d/%0d troca=%b/%b",
                 $time, buzzer, m_buz, tocando, (m_state == M_TOC), nota_atual, m_acc,
                 troca, m_troca);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  function automatic int probe(input int which);
    case (which)
      0: return int'(nota_atual);
      1: return int'(tocando);
      2: return int'(buzzer);
      default: return int'(troca);
    endcase
  endfunction

  // Edges until probe==val (returns bound+1 on timeout).
  task automatic wait_cond(input int which, input int val, input int bound, output int n);
    n = 0;
    while (n <= bound) begin
      @(posedge clock); #1;
      n++;
      if (probe(which) == val) break;
    end
  endtask

  // Length of the run of samples equal to val, starting with the current one.
  task automatic run_len(input int which, input int val, input int bound, output int n);
    n = 1;
    forever begin
      @(posedge clock); #1;
      if (probe(which) != val || n > bound) break;
      n++;
    end
  endtask

  task automatic count_high(input int which, input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clock); #1;
      if (probe(which) == 1) n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    #1;
    check("reset_outputs", int'({buzzer, tocando, nota_atual, troca}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // A4 from silence
    enable = 1'b1; nota = 3'd6;
    wait_cond(0, 6, 20, n);
    check("a4_accept_latency", n, 5);
    @(posedge clock); #1;
    check("a4_troca", int'(troca), 1);
    check("a4_buzzer_rise", int'(buzzer), 1);
    check("a4_tocando", int'(tocando), 1);
    run_len(2, 1, 400, n);
    check("a4_half_period", n, 113);

    // Short glitch to E4 must be ignored
    @(negedge clock); nota = 3'd3;
    @(negedge clock); @(negedge clock); nota = 3'd6;
    count_high(3, 15, n);
    check("glitch_no_troca", n, 0);
    check("glitch_nota_atual", int'(nota_atual), 6);

    // Switch to C4: gap, then restart
    @(negedge clock); nota = 3'd1;
    wait_cond(1, 0, 20, n);
    check("artic_entry_latency", n, 6);
    run_len(1, 0, 100, n);
    check("artic_gap_len", n, GAP);
    check("c4_troca", int'(troca), 1);
    check("c4_buzzer_rise", int'(buzzer), 1);
    run_len(2, 1, 400, n);
    check("c4_half_period", n, 191);

    // Enable low silences
    @(negedge clock); enable = 1'b0;
    wait_cond(0, 0, 20, n);
    check("disable_latency", n, 5);
    @(posedge clock); #1;
    check("disable_tocando", int'(tocando), 0);
    check("disable_buzzer", int'(buzzer), 0);
    repeat (5) @(negedge clock);

    // Request returns to silence during the gap
    enable = 1'b1; nota = 3'd6;
    wait_cond(1, 1, 20, n);
    check("artic0_start", n, 6);
    @(negedge clock); nota = 3'd2;
    wait_cond(1, 0, 20, n);
    check("artic0_enter", n, 6);
    @(negedge clock); nota = 3'd0;
    count_high(3, 40, n);
    check("artic0_no_troca", n, 0);
    check("artic0_tocando", int'(tocando), 0);
    check("artic0_nota_atual", int'(nota_atual), 0);

    // Asynchronous reset mid-note
    @(negedge clock); nota = 3'd6;
    wait_cond(1, 1, 20, n);
    check("mid_start", n, 6);
    check("mid_buzzer_high", int'(buzzer), 1);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", int'({buzzer, tocando, nota_atual, troca}), 0);
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_cond(0, 6, 20, n);
    check("post_reset_accept", n, 5);
    @(posedge clock); #1;
    check("post_reset_troca", int'(troca), 1);
    check("post_reset_buzzer", int'(buzzer), 1);
    repeat (10) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
